dff_pattern_load: RTL and testbench



---
 rtl/dff_test_pkg.sv | 20 ++
 rtl/pi_input_sync.sv | 45 ++++
 rtl/dff_pattern_load.sv | 193 +++++++++++++++++++
 tb/tb_dff_pattern_load.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_test_pkg.sv
// Shared types and constants for the DFF test fixture pattern loader.
package dff_test_pkg;

    localparam int DFF_NUM_BITS    = 19;
    localparam int DFF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } dff_state_e;

    // Bit counter must hold NUM_BITS+1 (frame length with the optional parity bit).
    function automatic int dff_cnt_width(input int num_bits);
        return $clog2(num_bits + 2);
    endfunction

endpackage

// File: rtl/pi_input_sync.sv
// Synchronizer chain plus rising-edge detector for one slow Pi input.
// Edge pulses are masked for SYNC_STAGES+1 cycles after reset so a pin that
// is already high when reset releases does not look like a fresh edge.
module pi_input_sync
    import dff_test_pkg::*;
#(
    parameter int SYNC_STAGES = DFF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    localparam int SUP_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SUP_W-1:0]       r_sup;

    // Metastability chain followed by the edge-history register.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Post-reset mask counter; counts down to zero and stays there.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sup <= SUP_W'(SYNC_STAGES + 1);
        end else if (r_sup != '0) begin
            r_sup <= r_sup - SUP_W'(1);
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev & (r_sup == '0);

endmodule

// File: rtl/dff_pattern_load.sv
// Serial pattern loader: shifts a Pi-supplied frame in, commits it to the DUT
// D-inputs on a load strobe, then issues one DUT clock pulse after a setup gap.
// Optional feature macro: DFF_PARITY_EN (frame gains a trailing even-parity bit).
module dff_pattern_load
    import dff_test_pkg::*;
#(
    parameter int NUM_BITS    = DFF_NUM_BITS,
    parameter int SYNC_STAGES = DFF_SYNC_STAGES,
    parameter int SETUP_CYC   = 8,
    parameter int PULSE_CYC   = 4
) (
    input  logic                CLK_50M,
    input  logic                RST,
    input  logic                data_clk_pi_in,
    input  logic                data_in_pi,
    input  logic                load_pattern_pi,
    output logic [NUM_BITS-1:0] DB_DFFD,
    output logic                DB_DFF_CLK,
    output logic                pattern_ack_pi,
    output logic                frame_err_pi
);

`ifdef DFF_PARITY_EN
    localparam int FRAME_BITS = NUM_BITS + 1;
`else
    localparam int FRAME_BITS = NUM_BITS;
`endif
    localparam int CNT_W  = dff_cnt_width(NUM_BITS);
    localparam int PH_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    // Input index map: 0 = serial data, 1 = bit clock, 2 = load strobe.
    logic [2:0] w_pins;
    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic       w_unused;

    assign w_pins = {load_pattern_pi, data_clk_pi_in, data_in_pi};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pi_sync
            pi_input_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .i_clk   (CLK_50M),
                .i_srst  (RST),
                .i_async (w_pins[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    logic w_data;
    logic w_dclk_rise;
    logic w_load_rise;

    assign w_data      = w_level[0];
    assign w_dclk_rise = w_rise[1];
    assign w_load_rise = w_rise[2];
    assign w_unused    = ^{w_rise[0], w_level[2:1]};

    logic [FRAME_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_ovf;
    dff_state_e            r_state;
    logic [PH_W-1:0]       r_phase;
    logic [NUM_BITS-1:0]   r_dffd;
    logic                  r_dff_clk;
    logic                  r_ack;
    logic                  r_err;

    logic [FRAME_BITS-1:0] w_shreg_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic                  w_ovf_next;
    logic [NUM_BITS-1:0]   w_pattern;
    logic                  w_parity_ok;
    logic                  w_frame_ok;

    // Shift applied first so a same-cycle load sees the updated count.
    always_comb begin
        w_shreg_next = r_shreg;
        w_cnt_next   = r_bit_cnt;
        w_ovf_next   = r_ovf;
        if (w_dclk_rise) begin
            w_shreg_next = {r_shreg[FRAME_BITS-2:0], w_data};
            if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign w_pattern = w_shreg_next[FRAME_BITS-1 -: NUM_BITS];
`ifdef DFF_PARITY_EN
    assign w_parity_ok = ~(^w_shreg_next);
`else
    assign w_parity_ok = 1'b1;
`endif
    assign w_frame_ok = (w_cnt_next == CNT_W'(FRAME_BITS)) && !w_ovf_next && w_parity_ok;

    // Frame shift register and length tracking; a load in IDLE restarts the frame.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_shreg <= w_shreg_next;
            if (w_load_rise && (r_state == IDLE)) begin
                r_bit_cnt <= '0;
                r_ovf     <= 1'b0;
            end else begin
                r_bit_cnt <= w_cnt_next;
                r_ovf     <= w_ovf_next;
            end
        end
    end

    // Commit / setup / pulse / hold / done sequencer with registered outputs.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_dffd    <= '0;
            r_dff_clk <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_dclk_rise || w_load_rise) begin
                r_ack <= 1'b0;
            end
            if (w_load_rise && (r_state != IDLE)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_load_rise) begin
                        if (w_frame_ok) begin
                            r_dffd  <= w_pattern;
                            r_err   <= 1'b0;
                            r_phase <= '0;
                            r_state <= SETUP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (r_phase == PH_W'(SETUP_CYC - 1)) begin
                        r_dff_clk <= 1'b1;
                        r_phase   <= '0;
                        r_state   <= PULSE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                PULSE: begin
                    if (r_phase == PH_W'(PULSE_CYC - 1)) begin
                        r_dff_clk <= 1'b0;
                        r_phase   <= '0;
                        r_state   <= HOLD;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                HOLD: begin
                    if (r_phase == PH_W'(PULSE_CYC - 1)) begin
                        r_phase <= '0;
                        r_state <= DONE;
                    end else begin
                        r_phase <= r_phase + PH_W'(1);
                    end
                end
                DONE: begin
                    r_ack   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign DB_DFFD        = r_dffd;
    assign DB_DFF_CLK     = r_dff_clk;
    assign pattern_ack_pi = r_ack;
    assign frame_err_pi   = r_err;

endmodule

// File: tb/tb_dff_pattern_load.sv
// Self-checking bench for dff_pattern_load: randomized frames against a
// queue-based reference model, plus directed protocol and reset scenarios.
module tb_dff_pattern_load;

    localparam int NB = 19;
    localparam int SS = 2;
    localparam int SC = 8;
    localparam int PC = 4;
`ifdef DFF_PARITY_EN
    localparam int FB = NB + 1;
`else
    localparam int FB = NB;
`endif
    localparam int TRACE_LEN = 30;
    localparam int EXP_UPD   = SS + 1;
    localparam int EXP_RISE  = EXP_UPD + SC;
    localparam int EXP_ACK   = EXP_RISE + 2 * PC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_clk_pi_in = 1'b0;
    logic          data_in_pi = 1'b0;
    logic          load_pattern_pi = 1'b0;
    logic [NB-1:0] db_dffd;
    logic          db_dff_clk;
    logic          pattern_ack_pi;
    logic          frame_err_pi;

    dff_pattern_load #(
        .NUM_BITS(NB), .SYNC_STAGES(SS), .SETUP_CYC(SC), .PULSE_CYC(PC)
    ) dut (
        .CLK_50M         (clk),
        .RST             (rst),
        .data_clk_pi_in  (data_clk_pi_in),
        .data_in_pi      (data_in_pi),
        .load_pattern_pi (load_pattern_pi),
        .DB_DFFD         (db_dffd),
        .DB_DFF_CLK      (db_dff_clk),
        .pattern_ack_pi  (pattern_ack_pi),
        .frame_err_pi    (frame_err_pi)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: bits received since the last commit attempt, plus
    // the pattern and error flag the fixture should be presenting.
    bit            m_bits[$];
    logic [NB-1:0] m_pattern = '0;
    logic          m_err = 1'b0;

    // Per-commit measurements (cycle index counted from the load pin rise).
    int            t_upd, t_rise, t_high, t_ack_rise;
    logic          t_ack_at_upd;
    logic [NB-1:0] t_d0, t_final_d;
    logic          t_err_final, t_ack_final;

    task automatic send_bit(input bit b);
        data_in_pi = b;
        data_clk_pi_in = 1'b0;
        repeat (SS + 2) @(negedge clk);
        data_clk_pi_in = 1'b1;
        repeat (SS + 2) @(negedge clk);
        m_bits.push_back(b);
    endtask

    // Pattern MSB first, then the parity bit when enabled, then random filler.
    task automatic send_frame(input logic [NB-1:0] pat, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bit b;
            if (i < NB) b = pat[NB-1-i];
`ifdef DFF_PARITY_EN
            else if (i == NB) b = ^pat;
`endif
            else b = 1'($urandom_range(0, 1));
            send_bit(b);
        end
    endtask

    // Judge the queued frame by the protocol rules; returns 1 on a commit.
    function automatic bit model_commit();
        bit            ok;
        bit            par;
        logic [NB-1:0] pat;
        ok  = (m_bits.size() == FB);
        par = 1'b0;
        pat = '0;
        foreach (m_bits[i]) par ^= m_bits[i];
`ifdef DFF_PARITY_EN
        if (par) ok = 1'b0;
`endif
        if (ok) begin
            for (int i = 0; i < NB; i++) pat = {pat[NB-2:0], m_bits[i]};
            m_pattern = pat;
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        m_bits.delete();
        return ok;
    endfunction

    // Raise load now (caller sits at a negedge) and record what follows.
    task automatic run_trace(input int second_load_at);
        logic ack_prev;
        t_d0 = db_dffd;
        ack_prev = pattern_ack_pi;
        t_upd = -1; t_rise = -1; t_high = 0; t_ack_rise = -1; t_ack_at_upd = 1'bx;
        load_pattern_pi = 1'b1;
        for (int k = 1; k <= TRACE_LEN; k++) begin
            @(negedge clk);
            if (db_dffd !== t_d0 && t_upd < 0) t_upd = k;
            if (db_dff_clk === 1'b1 && t_rise < 0) t_rise = k;
            if (db_dff_clk === 1'b1) t_high++;
            if (pattern_ack_pi === 1'b1 && ack_prev !== 1'b1 && t_ack_rise < 0) t_ack_rise = k;
            if (k == EXP_UPD) t_ack_at_upd = pattern_ack_pi;
            ack_prev = pattern_ack_pi;
            load_pattern_pi = (k < 4) ||
                (second_load_at >= 0 && k >= second_load_at && k < second_load_at + 4);
        end
        load_pattern_pi = 1'b0;
        t_final_d = db_dffd;
        t_err_final = frame_err_pi;
        t_ack_final = pattern_ack_pi;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run += 4;
        if (db_dffd !== '0) begin tests_failed++; $display("FAIL reset_dffd: got %h expected 0", db_dffd); end
        if (db_dff_clk !== 1'b0) begin tests_failed++; $display("FAIL reset_clk: got %b expected 0", db_dff_clk); end
        if (pattern_ack_pi !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0", pattern_ack_pi); end
        if (frame_err_pi !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", frame_err_pi); end
        rst = 1'b0;
        repeat (SS + 3) @(negedge clk);
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_directed_commit();
        bit ok;
        send_frame(19'h5A5A5, FB);
        ok = model_commit();
        run_trace(-1);
        tests_run += 6;
        if (!ok || m_pattern !== 19'h5A5A5) begin tests_failed++; $display("FAIL directed_model: got %h expected 5a5a5", m_pattern); end
        if (t_final_d !== 19'h5A5A5) begin tests_failed++; $display("FAIL directed_d: got %h expected 5a5a5", t_final_d); end
        if (t_upd !== EXP_UPD) begin tests_failed++; $display("FAIL directed_upd: got %0d expected %0d", t_upd, EXP_UPD); end
        if (t_rise !== EXP_RISE) begin tests_failed++; $display("FAIL directed_rise: got %0d expected %0d", t_rise, EXP_RISE); end
        if (t_high !== PC) begin tests_failed++; $display("FAIL directed_width: got %0d expected %0d", t_high, PC); end
        if (t_ack_rise !== EXP_ACK) begin tests_failed++; $display("FAIL directed_ack: got %0d expected %0d", t_ack_rise, EXP_ACK); end
        $display("[TB] directed 0x5A5A5: d=%h rise=%0d width=%0d ack=%0d", t_final_d, t_rise, t_high, t_ack_rise);
    endtask

    task automatic test_ack_clear();
        bit ok;
        tests_run += 4;
        if (pattern_ack_pi !== 1'b1) begin tests_failed++; $display("FAIL ack_level: got %b expected 1", pattern_ack_pi); end
        send_bit(1'($urandom_range(0, 1)));
        if (pattern_ack_pi !== 1'b0) begin tests_failed++; $display("FAIL ack_clear: got %b expected 0", pattern_ack_pi); end
        ok = model_commit();
        run_trace(-1);
        if (t_err_final !== m_err || ok) begin tests_failed++; $display("FAIL ack_oneb_err: got %b expected %b", t_err_final, m_err); end
        if (t_rise !== -1) begin tests_failed++; $display("FAIL ack_oneb_pulse: got %0d expected -1", t_rise); end
        $display("[TB] ack clear then 1-bit load: err=%b", t_err_final);
    endtask

    task automatic test_short_then_full();
        bit ok;
        send_frame(NB'($urandom), FB - 1);
        ok = model_commit();
        run_trace(-1);
        tests_run += 3;
        if (t_err_final !== 1'b1 || ok) begin tests_failed++; $display("FAIL short_err: got %b expected 1", t_err_final); end
        if (t_final_d !== m_pattern || t_upd !== -1) begin tests_failed++; $display("FAIL short_d: got %h expected %h", t_final_d, m_pattern); end
        if (t_high !== 0) begin tests_failed++; $display("FAIL short_pulse: got %0d expected 0", t_high); end
        $display("[TB] short frame: err=%b d=%h", t_err_final, t_final_d);
        send_frame(19'h7FFFF, FB);
        ok = model_commit();
        run_trace(-1);
        tests_run += 3;
        if (t_final_d !== 19'h7FFFF || !ok) begin tests_failed++; $display("FAIL full_d: got %h expected 7ffff", t_final_d); end
        if (t_err_final !== 1'b0) begin tests_failed++; $display("FAIL full_err: got %b expected 0", t_err_final); end
        if (t_high !== PC) begin tests_failed++; $display("FAIL full_width: got %0d expected %0d", t_high, PC); end
        $display("[TB] full frame 0x7FFFF: d=%h err=%b", t_final_d, t_err_final);
    endtask

    task automatic test_overflow();
        bit ok;
        send_frame(NB'($urandom), FB + 1);
        ok = model_commit();
        run_trace(-1);
        tests_run += 3;
        if (t_err_final !== 1'b1 || ok) begin tests_failed++; $display("FAIL ovf_err: got %b expected 1", t_err_final); end
        if (t_final_d !== m_pattern) begin tests_failed++; $display("FAIL ovf_d: got %h expected %h", t_final_d, m_pattern); end
        if (t_high !== 0) begin tests_failed++; $display("FAIL ovf_pulse: got %0d expected 0", t_high); end
        $display("[TB] overflow frame: err=%b pulse=%0d", t_err_final, t_high);
    endtask

    task automatic test_load_during_pulse();
        bit ok;
        send_frame(NB'($urandom), FB);
        ok = model_commit();
        run_trace(EXP_RISE);
        m_err = 1'b1;
        tests_run += 4;
        if (t_final_d !== m_pattern || !ok) begin tests_failed++; $display("FAIL ldp_d: got %h expected %h", t_final_d, m_pattern); end
        if (t_err_final !== m_err) begin tests_failed++; $display("FAIL ldp_err: got %b expected 1", t_err_final); end
        if (t_high !== PC) begin tests_failed++; $display("FAIL ldp_width: got %0d expected %0d", t_high, PC); end
        if (t_ack_rise !== EXP_ACK) begin tests_failed++; $display("FAIL ldp_ack: got %0d expected %0d", t_ack_rise, EXP_ACK); end
        $display("[TB] load during pulse: d=%h err=%b width=%0d", t_final_d, t_err_final, t_high);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 8; n++) begin
            bit            ok;
            int            len;
            int            exp_upd;
            logic [NB-1:0] pat;
            case ($urandom_range(0, 3))
                0:       len = FB - 1;
                3:       len = FB + 1;
                default: len = FB;
            endcase
            pat = NB'($urandom);
            send_frame(pat, len);
            ok = model_commit();
            run_trace(-1);
            exp_upd = (ok && m_pattern !== t_d0) ? EXP_UPD : -1;
            tests_run += 6;
            if (t_final_d !== m_pattern) begin tests_failed++; $display("FAIL rnd%0d_d: got %h expected %h", n, t_final_d, m_pattern); end
            if (t_err_final !== m_err) begin tests_failed++; $display("FAIL rnd%0d_err: got %b expected %b", n, t_err_final, m_err); end
            if (t_upd !== exp_upd) begin tests_failed++; $display("FAIL rnd%0d_upd: got %0d expected %0d", n, t_upd, exp_upd); end
            if (t_rise !== (ok ? EXP_RISE : -1)) begin tests_failed++; $display("FAIL rnd%0d_rise: got %0d expected %0d", n, t_rise, ok ? EXP_RISE : -1); end
            if (t_high !== (ok ? PC : 0)) begin tests_failed++; $display("FAIL rnd%0d_width: got %0d expected %0d", n, t_high, ok ? PC : 0); end
            if (t_ack_at_upd !== 1'b0 || t_ack_final !== ok) begin tests_failed++; $display("FAIL rnd%0d_ack: got %b/%b expected 0/%b", n, t_ack_at_upd, t_ack_final, ok); end
            $display("[TB] random frame %0d: len=%0d pat=%h commit=%0d d=%h err=%b", n, len, pat, ok, t_final_d, t_err_final);
        end
    endtask

`ifdef DFF_PARITY_EN
    task automatic test_parity();
        bit ok;
        send_frame(19'h00001, FB);
        ok = model_commit();
        run_trace(-1);
        tests_run += 2;
        if (t_final_d !== 19'h00001 || !ok) begin tests_failed++; $display("FAIL par_good_d: got %h expected 00001", t_final_d); end
        if (t_high !== PC) begin tests_failed++; $display("FAIL par_good_width: got %0d expected %0d", t_high, PC); end
        send_frame(19'h00001, NB);
        send_bit(1'b0);
        ok = model_commit();
        run_trace(-1);
        tests_run += 2;
        if (t_err_final !== 1'b1 || ok) begin tests_failed++; $display("FAIL par_bad_err: got %b expected 1", t_err_final); end
        if (t_high !== 0) begin tests_failed++; $display("FAIL par_bad_pulse: got %0d expected 0", t_high); end
        $display("[TB] parity good/bad: err=%b", t_err_final);
    endtask
`endif

    task automatic test_reset_during_pulse();
        bit            ok;
        bit            seen;
        logic [NB-1:0] pat;
        send_frame(NB'($urandom) | NB'(1), FB);
        ok = model_commit();
        seen = 1'b0;
        load_pattern_pi = 1'b1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k >= 4) load_pattern_pi = 1'b0;
            if (db_dff_clk === 1'b1) seen = 1'b1;
        end
        tests_run += 1;
        if (!seen || !ok) begin tests_failed++; $display("FAIL rstp_wait: got no pulse within 40 cycles expected pulse"); end
        rst = 1'b1;
        @(negedge clk);
        tests_run += 4;
        if (db_dff_clk !== 1'b0) begin tests_failed++; $display("FAIL rstp_clk: got %b expected 0", db_dff_clk); end
        if (db_dffd !== '0) begin tests_failed++; $display("FAIL rstp_d: got %h expected 0", db_dffd); end
        if (pattern_ack_pi !== 1'b0) begin tests_failed++; $display("FAIL rstp_ack: got %b expected 0", pattern_ack_pi); end
        if (frame_err_pi !== 1'b0) begin tests_failed++; $display("FAIL rstp_err: got %b expected 0", frame_err_pi); end
        load_pattern_pi = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_bits.delete();
        m_pattern = '0;
        m_err = 1'b0;
        repeat (10) @(negedge clk);
        pat = NB'($urandom);
        send_frame(pat, FB);
        ok = model_commit();
        run_trace(-1);
        tests_run += 3;
        if (t_final_d !== m_pattern || !ok) begin tests_failed++; $display("FAIL rstp_after_d: got %h expected %h", t_final_d, m_pattern); end
        if (t_err_final !== 1'b0) begin tests_failed++; $display("FAIL rstp_after_err: got %b expected 0", t_err_final); end
        if (t_rise !== EXP_RISE) begin tests_failed++; $display("FAIL rstp_after_rise: got %0d expected %0d", t_rise, EXP_RISE); end
        $display("[TB] reset during pulse then frame %h: d=%h err=%b", pat, t_final_d, t_err_final);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed_commit();
        test_ack_clear();
        test_short_then_full();
        test_overflow();
        test_load_during_pulse();
        test_random_frames();
`ifdef DFF_PARITY_EN
        test_parity();
`endif
        test_reset_during_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
